picomips_ctrl: RTL and testbench
================================

Name: picomips_ctrl

Overview:
- Multicycle sequencer for picoMIPS; sits directly upstream of the gpr block (regs).
- Fetches an instruction from program memory, decodes it and drives the register-file ports (Rsno, Rdno, w, Wdata).
- Sequences the ALU, handles the switch-input handshake, updates the program counter and executes branches.
- One instruction per 4 cycles; the input instruction waits for the switch handshake.

Parameters:
- n, 8, data width (matches regs n)
- PCW, 6, program counter width
- IW, 22, instruction width

Ports:
- clk  in  1  system clock, all state on rising edge
- nReset  in  1  asynchronous active-low reset
- pc  out  PCW  program memory address
- instr  in  IW  instruction word, combinational from program memory at pc
- Rsno  out  5  gpr source register number
- Rdno  out  5  gpr destination register number
- w  out  1  gpr write enable
- Wdata  out  n  gpr write data
- alu_func  out  3  ALU operation code
- imm  out  n  immediate operand to ALU B mux
- imm_sel  out  1  1 = ALU B takes imm, 0 = Rs
- alu_result  in  n  ALU result
- alu_zero  in  1  ALU result == 0
- sw_data  in  n  switch input value
- sw_valid  in  1  switch data ready (level)
- sw_ack  out  1  one-cycle pulse, switch data consumed
- halted  out  1  high in HALT state

Behaviour:
- Instruction fields: op = instr[21:18], rd = instr[17:13], rs = instr[12:8], imm = instr[7:0].
- Opcodes:
  - 0 NOP
  - 1 ADD (Rd = Rd + Rs)
  - 2 ADDI (Rd = Rd + imm)
  - 3 SUB (Rd = Rd - Rs)
  - 4 MULI (Rd = Rd * imm, upper byte)
  - 5 LDSW (Rd = sw_data)
  - 6 BEQ (if Rd == Rs then pc += signed imm)
  - 7 HALT
  - 8-15 treated as NOP.
- FSM states: FETCH, DECODE, EXEC, WB, WAIT_IN, HALT.
- FETCH: IR <= instr; next DECODE.
- DECODE: Rdno/Rsno driven from IR (held through WB). Next state:
  - op 5: WAIT_IN
  - op 7: HALT
  - otherwise: EXEC
- EXEC: alu_func, imm_sel, imm valid; result register <= alu_result; zero flag latched. Next state:
  - ops 1-4: WB
  - op 0, op 6, undefined ops: FETCH
- WAIT_IN: holds until sw_valid = 1. Result register <= sw_data; sw_ack = 1 for that cycle only; next WB.
- WB: w = 1 for exactly one cycle, Wdata = result register; next FETCH.
- HALT: terminal; leaves only via reset; w = 0, pc frozen, halted = 1.
- PC update, on every transition into FETCH:
  - BEQ with zero taken: pc <= pc + sign-extended imm[PCW-1:0], modulo 2^PCW (wrap-around both directions; imm = 0 gives a self-loop).
  - Otherwise: pc <= pc + 1, wrapping from 2^PCW-1 to 0.
- alu_func encoding: 0 PASS, 1 ADD, 2 SUB, 3 MUL. BEQ uses SUB, imm_sel = 0.
- w is asserted only in WB; never for NOP, BEQ or HALT. Writes to register 0 are permitted.
- Reset (asynchronous, any state, including mid-WAIT_IN or WB):
  - state = FETCH, pc = 0, IR = 0
  - result = 0, w = 0, sw_ack = 0, halted = 0
  - Rsno = Rdno = 0, Wdata = 0, imm = 0, imm_sel = 0, alu_func = 0
- sw_valid already high on entry to WAIT_IN: ack in the first WAIT_IN cycle, so LDSW takes 4 cycles. Each extra waiting cycle adds 1.
- sw_valid outside WAIT_IN is ignored.

Decomposition:
- Package picomips_pkg holds:
  - opcode enum (4 bits)
  - alu_func enum
  - FSM state enum
  - instruction field bit positions
- Sub-module pc_unit (PC register, increment/branch adder, wrap) is natural. Everything else stays in picomips_ctrl.

Test Plan:
- Reset then ADDI rd=1, imm=10 at pc 0 -> w high exactly in cycle 4 with Rdno = 1, Wdata = alu_result (10 when ALU model driven); pc = 1 at cycle 5.
- LDSW rd=2 with sw_valid low for 3 cycles, then sw_data = 8'd13 with sw_valid high -> single sw_ack pulse, then w = 1, Rdno = 2, Wdata = 13. Total latency 7 cycles.
- BEQ at pc 5, imm = 8'hFD, alu_zero = 1 -> pc = 2; same with alu_zero = 0 -> pc = 6; no w pulse in either case.
- pc = 63 with NOP -> pc wraps to 0; BEQ at pc 62, imm = 4, taken -> pc = 2.
- HALT at pc 3 -> halted = 1, pc stays 3, w stays 0 for 20 cycles; nReset low -> pc = 0, halted = 0 immediately without waiting for a clock.
- nReset asserted during WB of an ADD -> w drops to 0 asynchronously; after release, fetch restarts from pc 0.

Source files
------------

// File: rtl/picomips_pkg.sv
// picomips_pkg: shared definitions for the picoMIPS control sequencer.
//   opcode_e   - 4-bit instruction opcodes (8..15 decode as NOP)
//   alu_func_e - ALU operation select driven to the datapath
//   state_e    - sequencer FSM states
//   field positions of the 22-bit instruction word and small decode helpers
package picomips_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_SUB  = 4'd3,
    OP_MULI = 4'd4,
    OP_LDSW = 4'd5,
    OP_BEQ  = 4'd6,
    OP_HALT = 4'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3
  } alu_func_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_WAIT_IN,
    S_HALT
  } state_e;

  localparam int unsigned OP_MSB  = 21;
  localparam int unsigned OP_LSB  = 18;
  localparam int unsigned RD_MSB  = 17;
  localparam int unsigned RD_LSB  = 13;
  localparam int unsigned RS_MSB  = 12;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  // Ops that go through EXEC and then write back the ALU result.
  function automatic logic is_write_op(opcode_e op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) || (op == OP_MULI);
  endfunction

  function automatic logic uses_imm(opcode_e op);
    return (op == OP_ADDI) || (op == OP_MULI);
  endfunction

  function automatic alu_func_e alu_for(opcode_e op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB, OP_BEQ:  return ALU_SUB;
      OP_MULI:         return ALU_MUL;
      default:         return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/picomips_ctrl_if.sv
// picomips_ctrl_if: bundle between the sequencer and its environment
// (program memory, gpr file, ALU, switch input).
//   master - sequencer side: drives pc, Rsno, Rdno, w, Wdata, alu_func,
//            imm, imm_sel, sw_ack, halted; samples instr, alu_result,
//            alu_zero, sw_data, sw_valid
//   slave  - environment side, directions mirrored
interface picomips_ctrl_if #(
  parameter int unsigned n   = 8,
  parameter int unsigned PCW = 6,
  parameter int unsigned IW  = 22
);
  logic [PCW-1:0] pc;
  logic [IW-1:0]  instr;
  logic [4:0]     Rsno;
  logic [4:0]     Rdno;
  logic           w;
  logic [n-1:0]   Wdata;
  logic [2:0]     alu_func;
  logic [n-1:0]   imm;
  logic           imm_sel;
  logic [n-1:0]   alu_result;
  logic           alu_zero;
  logic [n-1:0]   sw_data;
  logic           sw_valid;
  logic           sw_ack;
  logic           halted;

  modport master (
    output pc, Rsno, Rdno, w, Wdata, alu_func, imm, imm_sel, sw_ack, halted,
    input  instr, alu_result, alu_zero, sw_data, sw_valid
  );

  modport slave (
    input  pc, Rsno, Rdno, w, Wdata, alu_func, imm, imm_sel, sw_ack, halted,
    output instr, alu_result, alu_zero, sw_data, sw_valid
  );
endinterface

// File: rtl/picomips_ctrl_pc_unit.sv
// pc_unit: program counter register with increment / relative-branch adder.
//   clk_i, rst_ni - clock, asynchronous active-low reset (pc -> 0)
//   adv_i         - update pc this cycle (transition into FETCH)
//   taken_i       - branch taken: add offs_i instead of 1
//   offs_i        - low PCW bits of the branch immediate (two's complement)
//   pc_o          - current program counter; wraps modulo 2^PCW
module pc_unit #(
  parameter int unsigned PCW = 6
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           adv_i,
  input  logic           taken_i,
  input  logic [PCW-1:0] offs_i,
  output logic [PCW-1:0] pc_o
);
  logic [PCW-1:0] pc_q, pc_d;

  // Truncating the immediate to PCW bits and adding modulo 2^PCW is the
  // same as adding the sign-extended value, so no explicit extension.
  always_comb begin
    pc_d = pc_q;
    if (adv_i) pc_d = pc_q + (taken_i ? offs_i : PCW'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/picomips_ctrl.sv
// picomips_ctrl: multicycle picoMIPS sequencer (FETCH/DECODE/EXEC/WB,
// plus WAIT_IN for the switch handshake and a terminal HALT).
//   clk    - system clock
//   nReset - asynchronous active-low reset
//   bus    - picomips_ctrl_if.master: program memory, gpr, ALU and
//            switch-input signals
module picomips_ctrl
  import picomips_pkg::*;
#(
  parameter int unsigned n   = 8,
  parameter int unsigned PCW = 6,
  parameter int unsigned IW  = 22
) (
  input logic             clk,
  input logic             nReset,
  picomips_ctrl_if.master bus
);
  state_e         state_q;
  logic [IW-1:0]  ir_q;
  logic [n-1:0]   result_q;
  logic [n-1:0]   imm_q;
  logic [4:0]     rd_q, rs_q;
  logic           w_q, halted_q, imm_sel_q;
  alu_func_e      alu_func_q;
  opcode_e        op;
  logic           pc_adv, pc_taken;
  logic [PCW-1:0] pc;

  assign op = opcode_e'(ir_q[OP_MSB:OP_LSB]);

  // pc moves on every entry into FETCH; the branch decision uses alu_zero
  // at the EXEC edge directly since that is the same edge that leaves EXEC.
  assign pc_adv   = (state_q == S_WB) || ((state_q == S_EXEC) && !is_write_op(op));
  assign pc_taken = (state_q == S_EXEC) && (op == OP_BEQ) && bus.alu_zero;

  pc_unit #(.PCW(PCW)) u_pc (
    .clk_i  (clk),
    .rst_ni (nReset),
    .adv_i  (pc_adv),
    .taken_i(pc_taken),
    .offs_i (ir_q[IMM_LSB +: PCW]),
    .pc_o   (pc)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      result_q   <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      w_q        <= 1'b0;
      halted_q   <= 1'b0;
      imm_sel_q  <= 1'b0;
      alu_func_q <= ALU_PASS;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= bus.instr;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          rd_q       <= ir_q[RD_MSB:RD_LSB];
          rs_q       <= ir_q[RS_MSB:RS_LSB];
          imm_q      <= n'(ir_q[IMM_MSB:IMM_LSB]);
          imm_sel_q  <= uses_imm(op);
          alu_func_q <= alu_for(op);
          if (op == OP_LDSW) begin
            state_q <= S_WAIT_IN;
          end else if (op == OP_HALT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= bus.alu_result;
          if (is_write_op(op)) begin
            w_q     <= 1'b1;
            state_q <= S_WB;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_WAIT_IN: begin
          if (bus.sw_valid) begin
            result_q <= bus.sw_data;
            w_q      <= 1'b1;
            state_q  <= S_WB;
          end
        end
        S_WB: begin
          w_q     <= 1'b0;
          state_q <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Acknowledge in the same cycle the data is taken so an already-valid
  // switch costs no extra cycle.
  assign bus.sw_ack   = (state_q == S_WAIT_IN) && bus.sw_valid;
  assign bus.pc       = pc;
  assign bus.Rsno     = rs_q;
  assign bus.Rdno     = rd_q;
  assign bus.w        = w_q;
  assign bus.Wdata    = result_q;
  assign bus.alu_func = alu_func_q;
  assign bus.imm      = imm_q;
  assign bus.imm_sel  = imm_sel_q;
  assign bus.halted   = halted_q;
endmodule

// File: tb/tb_picomips_ctrl.sv
// tb_picomips_ctrl: drives picomips_ctrl with a program memory, a gpr/ALU
// environment and a switch source; an instruction-level model predicts
// every cycle's outputs, plus directed scenarios with literal expectations.
module tb_picomips_ctrl;
  localparam int unsigned N   = 8;
  localparam int unsigned PCW = 6;
  localparam int unsigned IW  = 22;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  picomips_ctrl_if #(.n(N), .PCW(PCW), .IW(IW)) bus ();
  picomips_ctrl #(.n(N), .PCW(PCW), .IW(IW)) dut (
    .clk   (clk),
    .nReset(nReset),
    .bus   (bus)
  );

  logic [IW-1:0] prog     [64];
  logic [N-1:0]  env_regs [32];
  logic [N-1:0]  m_regs   [32];
  logic          sw_valid = 1'b0;
  logic [N-1:0]  sw_data  = '0;
  bit            rand_sw  = 1'b0;
  int            checks   = 0;
  int            errors   = 0;
  int            m_pc     = 0;

  // ---------------- environment: program memory, gpr, ALU ----------------
  assign bus.instr    = prog[bus.pc];
  assign bus.sw_valid = sw_valid;
  assign bus.sw_data  = sw_data;

  logic [N-1:0]   alu_a, alu_b, alu_r;
  logic [2*N-1:0] prod;
  always_comb begin
    alu_a = env_regs[bus.Rdno];
    alu_b = bus.imm_sel ? bus.imm : env_regs[bus.Rsno];
    prod  = alu_a * alu_b;
    case (bus.alu_func)
      3'd0:    alu_r = alu_b;
      3'd1:    alu_r = alu_a + alu_b;
      3'd2:    alu_r = alu_a - alu_b;
      default: alu_r = prod[2*N-1:N];
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = (alu_r == '0);

  always @(posedge clk) if (nReset && bus.w) env_regs[bus.Rdno] <= bus.Wdata;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_sw) begin
        sw_valid = ($urandom_range(0, 3) == 0);
        sw_data  = N'($urandom);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk(int op, int rd, int rs, int im);
    logic [3:0] o;
    logic [4:0] d, s;
    logic [7:0] i;
    o = op[3:0]; d = rd[4:0]; s = rs[4:0]; i = im[7:0];
    return {o, d, s, i};
  endfunction

  task automatic set_reg(input int idx, input logic [N-1:0] v);
    env_regs[idx] <= v;
    m_regs[idx] = v;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) prog[i] = mk(0, 0, 0, 0);
  endtask

  task automatic reset_on();
    @(negedge clk);
    #1 nReset = 1'b0;
  endtask

  task automatic reset_off();
    @(negedge clk);
    @(posedge clk);
    #1 nReset = 1'b1;
  endtask

  task automatic wait_pc(input int target, input int budget);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (bus.pc !== PCW'(target) && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    chk("wait_pc", bus.pc, target);
  endtask

  // ---------------- instruction-level model + per-cycle compare ----------------
  // k counts cycles within the current instruction (1 = fetch cycle).
  initial begin
    int k, op, rd, rs, im, a, b, tmp, exp_af, exp_is;
    bit in_wb, wr_op, w_exp, ack_exp, done;
    logic [IW-1:0] ins;
    logic [N-1:0] exp_val, sw_cap;
    k = 1; in_wb = 0; op = 0; rd = 0; w_exp = 0; ack_exp = 0; wr_op = 0;
    exp_val = '0; sw_cap = '0; a = 0; b = 0; im = 0;
    forever begin
      @(negedge clk);
      if (!nReset) begin
        chk("rst_pc", bus.pc, 0);
        chk("rst_w", bus.w, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_sw_ack", bus.sw_ack, 0);
        chk("rst_Rsno", bus.Rsno, 0);
        chk("rst_Rdno", bus.Rdno, 0);
        chk("rst_Wdata", bus.Wdata, 0);
        chk("rst_imm", bus.imm, 0);
        chk("rst_imm_sel", bus.imm_sel, 0);
        chk("rst_alu_func", bus.alu_func, 0);
        k = 1; in_wb = 0; m_pc = 0;
      end else begin
        ins = prog[m_pc];
        op = int'(ins[21:18]); rd = int'(ins[17:13]); rs = int'(ins[12:8]); im = int'(ins[7:0]);
        a = int'(m_regs[rd]); b = int'(m_regs[rs]);
        wr_op   = (op >= 1 && op <= 4);
        ack_exp = (op == 5) && (k >= 3) && !in_wb && sw_valid;
        w_exp   = wr_op ? (k == 4) : ((op == 5) ? in_wb : 1'b0);
        chk("pc", bus.pc, m_pc);
        chk("halted", bus.halted, (op == 7) && (k >= 3));
        chk("sw_ack", bus.sw_ack, ack_exp);
        chk("w", bus.w, w_exp);
        if (k >= 3) begin
          chk("Rdno", bus.Rdno, rd);
          chk("Rsno", bus.Rsno, rs);
        end
        if (k == 3 && op != 5 && op != 7) begin
          exp_af = (op == 1 || op == 2) ? 1 : (op == 3 || op == 6) ? 2 : (op == 4) ? 3 : 0;
          exp_is = (op == 2 || op == 4) ? 1 : 0;
          chk("alu_func", bus.alu_func, exp_af);
          chk("imm_sel", bus.imm_sel, exp_is);
          chk("imm", bus.imm, im);
        end
        if (ack_exp) sw_cap = sw_data;
        if (w_exp) begin
          case (op)
            1: tmp = a + b;
            2: tmp = a + im;
            3: tmp = a - b;
            4: tmp = (a * im) >> 8;
            default: tmp = int'(sw_cap);
          endcase
          exp_val = tmp[N-1:0];
          chk("Wdata", bus.Wdata, exp_val);
        end
      end
      @(posedge clk);
      if (!nReset) begin
        k = 1; in_wb = 0; m_pc = 0;
      end else begin
        done = 0;
        if (op == 7) done = 0;
        else if (wr_op) done = (k == 4);
        else if (op == 5) begin
          if (in_wb) done = 1;
          else if (ack_exp) in_wb = 1;
        end else done = (k == 3);
        if (done) begin
          if (w_exp) m_regs[rd] = exp_val;
          if (op == 6 && a == b) m_pc = (m_pc + im) % 64;
          else                   m_pc = (m_pc + 1) % 64;
          k = 1; in_wb = 0;
        end else if (k < 1000) begin
          k++;
        end
      end
    end
  end

  // ---------------- directed scenarios + random run ----------------
  initial begin
    fill_nop();
    for (int i = 0; i < 32; i++) set_reg(i, N'($urandom));
    repeat (2) @(negedge clk);
    chk("reset_pc_lit", bus.pc, 0);

    // ADDI r1,10 then LDSW r2 with the switch late by 3 cycles
    prog[0] = mk(2, 1, 0, 10);
    prog[1] = mk(5, 2, 0, 0);
    set_reg(1, 0);
    reset_off();
    @(negedge clk); chk("A_pc0", bus.pc, 0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("A_w_c4", bus.w, 1); chk("A_Rdno", bus.Rdno, 1); chk("A_Wdata", bus.Wdata, 10);
    @(negedge clk); chk("A_pc1", bus.pc, 1);
    repeat (4) @(negedge clk);
    chk("L_noack", bus.sw_ack, 0); chk("L_now", bus.w, 0);
    @(posedge clk); #1 sw_valid = 1'b1; sw_data = 8'd13;
    @(negedge clk); chk("L_ack", bus.sw_ack, 1);
    @(posedge clk); #1 sw_valid = 1'b0;
    @(negedge clk);
    chk("L_w", bus.w, 1); chk("L_Rdno", bus.Rdno, 2); chk("L_Wdata", bus.Wdata, 13);
    chk("L_ack_once", bus.sw_ack, 0);
    @(negedge clk); chk("L_pc2", bus.pc, 2);

    // BEQ at 5, imm FD: taken -> 2
    reset_on(); fill_nop(); prog[5] = mk(6, 3, 3, 'hFD); reset_off();
    wait_pc(5, 100);
    repeat (2) @(negedge clk); chk("B_w", bus.w, 0);
    @(negedge clk); chk("B_taken_pc", bus.pc, 2);

    // BEQ at 5 not taken -> 6
    reset_on(); set_reg(3, 7); set_reg(4, 9); prog[5] = mk(6, 3, 4, 'hFD); reset_off();
    wait_pc(5, 100);
    repeat (2) @(negedge clk); chk("B_nt_w", bus.w, 0);
    @(negedge clk); chk("B_nt_pc", bus.pc, 6);

    // pc wrap 63 -> 0, and BEQ at 62 +4 -> 2
    reset_on(); fill_nop(); reset_off();
    wait_pc(63, 400);
    repeat (3) @(negedge clk); chk("W_wrap", bus.pc, 0);
    reset_on(); prog[62] = mk(6, 3, 3, 4); reset_off();
    wait_pc(62, 400);
    repeat (3) @(negedge clk); chk("W_beq_wrap", bus.pc, 2);

    // HALT at 3, then asynchronous reset
    reset_on(); fill_nop(); prog[3] = mk(7, 0, 0, 0); reset_off();
    wait_pc(3, 100);
    repeat (2) @(negedge clk); chk("H_halted", bus.halted, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("H_pc", bus.pc, 3); chk("H_w", bus.w, 0); chk("H_hold", bus.halted, 1);
    end
    #2 nReset = 1'b0;
    #1 chk("H_rst_pc", bus.pc, 0); chk("H_rst_halted", bus.halted, 0);
    reset_off();

    // reset during WB of ADD aborts the write
    reset_on(); fill_nop(); prog[0] = mk(1, 1, 2, 0); set_reg(1, 5); set_reg(2, 6); reset_off();
    repeat (4) @(negedge clk); chk("E_w", bus.w, 1); chk("E_Wdata", bus.Wdata, 11);
    #1 nReset = 1'b0;
    #1 chk("E_w_async", bus.w, 0);
    reset_off();
    @(negedge clk); chk("E_pc0", bus.pc, 0);
    repeat (3) @(negedge clk); chk("E_w2", bus.w, 1); chk("E_Wdata2", bus.Wdata, 11);

    // random programs (no HALT), random switch traffic, random resets
    rand_sw = 1'b1;
    for (int seg = 0; seg < 5; seg++) begin
      reset_on();
      for (int i = 0; i < 64; i++) begin
        int op;
        op = $urandom_range(0, 15);
        if (op == 7) op = 0;
        prog[i] = mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
      end
      reset_off();
      repeat ($urandom_range(300, 700)) @(negedge clk);
      #($urandom_range(1, 8)) nReset = 1'b0;
    end
    reset_off();
    rand_sw = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
